// File: rtl/uart_rx_even_if.sv
// Received-byte handshake bundle: byte, status flags, valid/ready.
interface uart_rx_even_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_even.sv
// UART receiver, 16x oversampled, 8N1 (8E1 when UART_RX_PARITY_EN is defined).
// Latency: byte presented the cycle after the stop-bit majority sample.
// Backpressure: one-byte holding register; a byte completing while it is full is dropped and flags overrun.
module uart_rx_even #(
    parameter int OVS_DIV = 326
) (
    input  logic            clk50m,
    input  logic            rst,
    input  logic            rxd,
    uart_rx_even_if.master  rx_if
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic        rxd_s1, rxd_s2, rxd_prev;
    logic [11:0] pre_cnt;
    logic        tick;
    logic [3:0]  tick_cnt;
    logic [2:0]  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        smp7, smp8;
    logic        vote;
    logic        mid_tick, last_tick;
    logic        start_edge;
    logic        complete;
    logic        perr_next;

    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        frame_err_q;
    logic        overrun_q;

    always_ff @(posedge clk50m or negedge rst) begin
        if (!rst) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    always_comb begin
        tick       = (pre_cnt == 12'(OVS_DIV - 1));
        start_edge = (state == S_IDLE) && rxd_prev && !rxd_s2;
        vote       = (smp7 & smp8) | (smp7 & rxd_s2) | (smp8 & rxd_s2);
        mid_tick   = tick && (tick_cnt == 4'd9);
        last_tick  = tick && (tick_cnt == 4'd15);
        complete   = (state == S_STOP) && mid_tick;
    end

    // Restarting the prescaler on the start edge phase-aligns ticks to the frame.
    always_ff @(posedge clk50m or negedge rst) begin
        if (!rst)
            pre_cnt <= '0;
        else if (start_edge || tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 12'd1;
    end

    always_ff @(posedge clk50m or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            smp7     <= 1'b1;
            smp8     <= 1'b1;
        end else begin
            if (state != S_IDLE && state != S_BREAK && tick) begin
                tick_cnt <= tick_cnt + 4'd1;
                if (tick_cnt == 4'd7) smp7 <= rxd_s2;
                if (tick_cnt == 4'd8) smp8 <= rxd_s2;
            end
            case (state)
                S_IDLE: begin
                    if (start_edge) begin
                        state    <= S_START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end
                end
                S_START: begin
                    if (mid_tick && vote)
                        state <= S_IDLE;
                    else if (last_tick)
                        state <= S_DATA;
                end
                S_DATA: begin
                    if (mid_tick)
                        shift <= {vote, shift[7:1]};
                    if (last_tick) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (last_tick)
                        state <= S_STOP;
                end
`endif
                S_STOP: begin
                    // A low stop bit means the line may be held in break; wait for it to recover.
                    if (mid_tick)
                        state <= vote ? S_IDLE : S_BREAK;
                end
                S_BREAK: begin
                    if (rxd_s2)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic parity_err_q;

    always_ff @(posedge clk50m or negedge rst) begin
        if (!rst)
            par_bit <= 1'b0;
        else if (state == S_PARITY && mid_tick)
            par_bit <= vote;
    end

    always_comb perr_next = (^shift) ^ par_bit;

    always_ff @(posedge clk50m or negedge rst) begin
        if (!rst)
            parity_err_q <= 1'b0;
        else if (complete && (!rx_valid_q || rx_if.rx_ready))
            parity_err_q <= perr_next;
    end

    assign rx_if.parity_err = parity_err_q;
`else
    always_comb perr_next = 1'b0;
    assign rx_if.parity_err = perr_next;
`endif

    always_ff @(posedge clk50m or negedge rst) begin
        if (!rst) begin
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (complete) begin
            if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_q   <= shift;
                frame_err_q <= !vote;
                rx_valid_q  <= 1'b1;
            end else begin
                overrun_q   <= 1'b1;
            end
        end else if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_even.sv
// Randomised and directed bench for uart_rx_even against a frame-level reference model.
module tb_uart_rx_even;

    localparam int OVS = 4;
    localparam int BIT = 16 * OVS;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } rec_t;

    logic clk50m = 1'b0;
    logic rst    = 1'b0;
    logic rxd    = 1'b1;
    bit   rdy_rand = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   vld_cycles = 0;
    rec_t obs_q[$];
    rec_t exp_q[$];

    uart_rx_even_if rx_if ();

    uart_rx_even #(.OVS_DIV(OVS)) dut (
        .clk50m (clk50m),
        .rst    (rst),
        .rxd    (rxd),
        .rx_if  (rx_if.master)
    );

    initial forever #10 clk50m = ~clk50m;

    always @(negedge clk50m) begin
        if (rst && rx_if.rx_valid) begin
            vld_cycles = vld_cycles + 1;
            if (rx_if.rx_ready)
                obs_q.push_back('{d: rx_if.rx_data, pe: rx_if.parity_err, fe: rx_if.frame_err});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk50m);
            #1;
            if (rdy_rand) rx_if.rx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    // Reference: what a correct receiver reports for a frame with these line bits.
    function automatic rec_t model(input logic [7:0] d, input bit pbit, input bit stop);
        rec_t r;
        r.d  = d;
        r.pe = PAR_EN ? ((^d) ^ pbit) : 1'b0;
        r.fe = !stop;
        return r;
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stop, input int stop_bits);
        rxd = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            wait_cyc(BIT);
        end
        if (PAR_EN) begin
            rxd = pbit;
            wait_cyc(BIT);
        end
        rxd = stop;
        wait_cyc(BIT * stop_bits);
        rxd = 1'b1;
        wait_cyc(BIT);
    endtask

    task automatic compare_q(input string tag);
        int n;
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, 32'(obs_q[i].d),  32'(exp_q[i].d));
            chk({tag, "_perr"}, 32'(obs_q[i].pe), 32'(exp_q[i].pe));
            chk({tag, "_ferr"}, 32'(obs_q[i].fe), 32'(exp_q[i].fe));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data"},    32'(rx_if.rx_data),    32'h00);
        chk({tag, "_valid"},   32'(rx_if.rx_valid),   32'h0);
        chk({tag, "_perr"},    32'(rx_if.parity_err), 32'h0);
        chk({tag, "_ferr"},    32'(rx_if.frame_err),  32'h0);
        chk({tag, "_overrun"}, 32'(rx_if.overrun),    32'h0);
    endtask

    initial begin
        logic [7:0] d;
        bit         pbit, stop;
        int         sb;

        rx_if.rx_ready = 1'b0;
        wait_cyc(5);
        chk_reset_outputs("reset");
        rst = 1'b1;
        wait_cyc(10);

        // Clean byte with ready held high: single-cycle valid pulse.
        rx_if.rx_ready = 1'b1;
        vld_cycles = 0;
        send_frame(8'hA5, 1'b0, 1'b1, 1);
        exp_q.push_back(model(8'hA5, 1'b0, 1'b1));
        compare_q("a5");
        chk("a5_valid_cycles", 32'(vld_cycles), 32'd1);

        send_frame(8'h01, 1'b0, 1'b1, 1);
        exp_q.push_back(model(8'h01, 1'b0, 1'b1));
        compare_q("x01");
        chk("x01_perr_hold", 32'(rx_if.parity_err), 32'(PAR_EN));

        // Glitch of 4 ticks, then a real frame starting right after tick 16.
        rxd = 1'b0;
        wait_cyc(4 * OVS);
        rxd = 1'b1;
        wait_cyc(12 * OVS);
        send_frame(8'h5A, ^8'h5A, 1'b1, 1);
        exp_q.push_back(model(8'h5A, ^8'h5A, 1'b1));
        compare_q("glitch");

        // Stop bit held low for 20 bit times (break), then a normal byte.
        send_frame(8'h3C, ^8'h3C, 1'b0, 20);
        chk("brk_ferr", 32'(rx_if.frame_err), 32'h1);
        chk("brk_count_mid", 32'(obs_q.size()), 32'd1);
        exp_q.push_back(model(8'h3C, ^8'h3C, 1'b0));
        send_frame(8'h55, ^8'h55, 1'b1, 1);
        exp_q.push_back(model(8'h55, ^8'h55, 1'b1));
        compare_q("brk");

        // Overrun: consumer stalls across two bytes.
        rx_if.rx_ready = 1'b0;
        send_frame(8'h11, ^8'h11, 1'b1, 1);
        chk("ovr_valid1", 32'(rx_if.rx_valid), 32'h1);
        chk("ovr_flag1",  32'(rx_if.overrun),  32'h0);
        send_frame(8'h22, ^8'h22, 1'b1, 1);
        chk("ovr_data",   32'(rx_if.rx_data),  32'h11);
        chk("ovr_valid2", 32'(rx_if.rx_valid), 32'h1);
        chk("ovr_flag2",  32'(rx_if.overrun),  32'h1);
        rx_if.rx_ready = 1'b1;
        wait_cyc(1);
        rx_if.rx_ready = 1'b0;
        chk("ovr_valid_clr", 32'(rx_if.rx_valid), 32'h0);
        chk("ovr_flag_clr",  32'(rx_if.overrun),  32'h0);
        chk("ovr_data_hold", 32'(rx_if.rx_data),  32'h11);
        exp_q.push_back(model(8'h11, ^8'h11, 1'b1));
        compare_q("ovr");

        // Reset in the middle of data bit 4 of 0xFF.
        rx_if.rx_ready = 1'b1;
        rxd = 1'b0;
        wait_cyc(BIT);
        rxd = 1'b1;
        wait_cyc(4 * BIT + BIT / 2);
        rst = 1'b0;
        wait_cyc(3);
        chk_reset_outputs("midrst");
        rst = 1'b1;
        wait_cyc(6 * BIT);
        send_frame(8'h42, ^8'h42, 1'b1, 1);
        exp_q.push_back(model(8'h42, ^8'h42, 1'b1));
        compare_q("midrst");

        // Random frames with random consumer stalls, parity and stop faults.
        rdy_rand = 1'b1;
        for (int k = 0; k < 24; k++) begin
            d    = 8'($urandom_range(0, 255));
            pbit = (^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            sb   = stop ? 1 : $urandom_range(1, 3);
            send_frame(d, pbit, stop, sb);
            exp_q.push_back(model(d, pbit, stop));
        end
        rdy_rand = 1'b0;
        rx_if.rx_ready = 1'b1;
        wait_cyc(BIT);
        compare_q("rand");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_even.md
UART_RX_EVEN -- requirements
Module: uart_rx_even

Interface
REQ-001 Parameter OVS_DIV, default 326, clk50m cycles per 16x-oversample tick (50 MHz / 9600 baud / 16); legal range 2..4095.
REQ-002 clk50m  in  1  single system clock; all logic on its rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 rxd  in  1  serial line; idles high; asynchronous to clk50m.
REQ-005 rx_data  out  8  last received byte.
REQ-006 rx_valid  out  1  rx_data holds an unconsumed byte.
REQ-007 rx_ready  in  1  consumer accepts rx_data when rx_valid=1 and rx_ready=1.
REQ-008 parity_err  out  1  parity check failed on the byte in rx_data.
REQ-009 frame_err  out  1  stop bit sampled low on the byte in rx_data.
REQ-010 overrun  out  1  sticky; a completed byte was discarded because rx_valid was still set.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 Prescaler counts 0..OVS_DIV-1 and emits one-cycle tick at OVS_DIV-1; it is forced to 0 on start-edge detect.
REQ-013 Bit timing uses a 4-bit tick counter: each bit lasts 16 ticks, with samples at ticks 7, 8 and 9, taken as a 2-of-3 majority vote.
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 IDLE->START on a synchronized 1->0 transition of rxd.
REQ-016 In START, a majority of 1 (false start) returns to IDLE with no output; otherwise go to DATA after tick 15.
REQ-017 DATA receives 8 bits LSB first, one per 16 ticks; then go to PARITY (macro defined) or STOP.
REQ-018 PARITY: even parity; parity_err = XOR of 8 data bits and parity sample.
REQ-019 STOP: on the stop majority vote, the byte completes; stop=0 sets frame_err.
REQ-020 After a completed byte: go to IDLE if stop=1; go to BREAK if stop=0. BREAK returns to IDLE when synchronized rxd=1.
REQ-021 Completion: rx_data, parity_err and frame_err load and rx_valid rises in the cycle after the stop-sample tick.
REQ-022 If rx_valid=1 and no handshake occurs that cycle, the new byte SHALL be discarded: rx_data and the error flags hold, and overrun is set.
REQ-023 A handshake in the same cycle as completion loads the new byte, rx_valid stays 1, and overrun is not set.
REQ-024 A handshake without completion clears rx_valid and overrun; rx_data holds its value.

Reset
REQ-025 rst=0 asynchronously forces: FSM IDLE; prescaler and counters 0; synchronizer flops 1; rx_data=0x00; rx_valid, parity_err, frame_err and overrun all 0.
REQ-026 Reset during a frame abandons that frame; after release, reception starts only on the next 1->0 edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN defined: frame is 8E1 (start, 8 data bits, even parity, stop).
REQ-028 UART_RX_PARITY_EN undefined: frame is 8N1; PARITY state, checker and parity flop are absent; parity_err is tied to 0.

Verification
REQ-029 Parity on, 0xA5 with parity bit 0, rx_ready=1 -> rx_data=0xA5, rx_valid pulses 1 cycle, parity_err=0, frame_err=0.
REQ-030 Parity on, 0x01 with parity bit 0 -> rx_data=0x01, parity_err=1.
REQ-031 rxd low for 4 ticks, then high -> no rx_valid; FSM back in IDLE before tick 16.
REQ-032 0x3C with stop bit held low for 20 bit times -> frame_err=1; next byte 0x55 is received only after rxd returns high.
REQ-033 rx_ready=0, bytes 0x11 then 0x22 -> rx_data=0x11, overrun=1; asserting rx_ready clears rx_valid and overrun.
REQ-034 rst asserted at DATA bit 4 of 0xFF, released, then 0x42 sent -> only 0x42 is delivered, with no error flags.
